// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and opcode encodings for the datapath
// Imported by the control unit and the ALU so both agree on encodings.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int RES_W  = 64;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // Places a 32-bit result in the LO word with a zero HI word.
  function automatic logic [RES_W-1:0] lo_only(input logic [DATA_W-1:0] value);
    return {{(RES_W-DATA_W){1'b0}}, value};
  endfunction

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - combinational signed 32/32 divider
// Quotient truncates toward zero; remainder follows the dividend's sign.
module alu_divider
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder
);

  logic              w_neg_a;
  logic              w_neg_b;
  logic              w_div_zero;
  logic              w_overflow;
  logic [DATA_W-1:0] w_mag_a;
  logic [DATA_W-1:0] w_mag_b;
  logic [DATA_W-1:0] w_den;
  logic [DATA_W-1:0] w_mag_q;
  logic [DATA_W-1:0] w_mag_r;
  logic [DATA_W-1:0] w_sgn_q;
  logic [DATA_W-1:0] w_sgn_r;

  assign w_neg_a    = i_dividend[DATA_W-1];
  assign w_neg_b    = i_divisor[DATA_W-1];
  assign w_div_zero = (i_divisor == '0);
  assign w_overflow = (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF);

  // Magnitudes stay correct for 0x80000000 because they are treated as unsigned.
  assign w_mag_a = w_neg_a ? (32'd0 - i_dividend) : i_dividend;
  assign w_mag_b = w_neg_b ? (32'd0 - i_divisor)  : i_divisor;
  assign w_den   = w_div_zero ? 32'd1 : w_mag_b;

  assign w_mag_q = w_mag_a / w_den;
  assign w_mag_r = w_mag_a % w_den;

  assign w_sgn_q = (w_neg_a ^ w_neg_b) ? (32'd0 - w_mag_q) : w_mag_q;
  assign w_sgn_r = w_neg_a ? (32'd0 - w_mag_r) : w_mag_r;

  always_comb begin
    o_quotient  = w_sgn_q;
    o_remainder = w_sgn_r;
    if (w_div_zero) begin
      o_quotient  = 32'hFFFF_FFFF;
      o_remainder = i_dividend;
    end else if (w_overflow) begin
      o_quotient  = 32'h8000_0000;
      o_remainder = '0;
    end
  end

endmodule

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - 32-bit single-bus ALU with a registered 64-bit result
// First operand from Y (RY), second from the bus (RB); RC = {HI, LO}.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] RA,
  input  logic [DATA_W-1:0] RB,
  input  logic [DATA_W-1:0] RY,
  input  logic [OP_W-1:0]   opcode,
  input  logic              brn_flag,
  input  logic              incPC,
  output logic [RES_W-1:0]  RC
);

  logic [RES_W-1:0]  r_rc;
  logic [RES_W-1:0]  w_next;
  logic [4:0]        w_amt;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_shra;
  logic [RES_W-1:0]  w_ror_wide;
  logic [RES_W-1:0]  w_rol_wide;
  logic [RES_W-1:0]  w_ry_sx;
  logic [RES_W-1:0]  w_rb_sx;
  logic [RES_W-1:0]  w_prod;
  logic [DATA_W-1:0] w_quot;
  logic [DATA_W-1:0] w_rem;
  logic              w_unused_ra;

  assign w_unused_ra = ^RA;

  assign w_amt  = RB[4:0];
  assign w_sum  = RY + RB;
  assign w_diff = RY - RB;
  assign w_shra = $signed(RY) >>> w_amt;

  // Rotates come from shifting a doubled copy of RY; amount 0 returns RY.
  assign w_ror_wide = {RY, RY} >> w_amt;
  assign w_rol_wide = {RY, RY} << w_amt;

  assign w_ry_sx = {{(RES_W-DATA_W){RY[DATA_W-1]}}, RY};
  assign w_rb_sx = {{(RES_W-DATA_W){RB[DATA_W-1]}}, RB};
  assign w_prod  = w_ry_sx * w_rb_sx;

  alu_divider u_div (
    .i_dividend  (RY),
    .i_divisor   (RB),
    .o_quotient  (w_quot),
    .o_remainder (w_rem)
  );

  always_comb begin
    w_next = '0;
    if (incPC) begin
      w_next = lo_only(RB + 32'd1);
    end else begin
      case (opcode)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: w_next = lo_only(w_sum);
        OP_SUB:                                w_next = lo_only(w_diff);
        OP_AND, OP_ANDI:                       w_next = lo_only(RY & RB);
        OP_OR, OP_ORI:                         w_next = lo_only(RY | RB);
        OP_SHR:                                w_next = lo_only(RY >> w_amt);
        OP_SHRA:                               w_next = lo_only(w_shra);
        OP_SHL:                                w_next = lo_only(RY << w_amt);
        OP_ROR:                                w_next = lo_only(w_ror_wide[DATA_W-1:0]);
        OP_ROL:                                w_next = lo_only(w_rol_wide[RES_W-1:DATA_W]);
        OP_MUL:                                w_next = w_prod;
        OP_DIV:                                w_next = {w_rem, w_quot};
        OP_NEG:                                w_next = lo_only(32'd0 - RB);
        OP_NOT:                                w_next = lo_only(~RB);
        OP_BR:                                 w_next = lo_only(brn_flag ? w_sum : RY);
        OP_JR, OP_JAL, OP_IN, OP_OUT,
        OP_MFHI, OP_MFLO, OP_NOP, OP_HALT:     w_next = lo_only(RB);
        default:                               w_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_rc <= '0;
    end else begin
      r_rc <= w_next;
    end
  end

  assign RC = r_rc;

endmodule

// File: tb/tb_cpu_alu.sv
// tb/tb_cpu_alu.sv - directed scoreboard bench for cpu_alu
module tb_cpu_alu;
  import cpu_pkg::*;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] RA;
  logic [31:0] RB;
  logic [31:0] RY;
  logic [4:0]  opcode;
  logic        brn_flag;
  logic        incPC;
  logic [63:0] RC;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cpu_alu dut (
    .clk      (clk),
    .clear    (clear),
    .RA       (RA),
    .RB       (RB),
    .RY       (RY),
    .opcode   (opcode),
    .brn_flag (brn_flag),
    .incPC    (incPC),
    .RC       (RC)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] ry, input logic [31:0] rb,
                       input logic brn, input logic inc);
    opcode   = op;
    RY       = ry;
    RB       = rb;
    brn_flag = brn;
    incPC    = inc;
    RA       = $urandom;
  endtask

  task automatic push_exp(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_underflow: observed %h expected none pending", RC);
    end else begin
      e = sb.pop_front();
      check(e.tag, RC, e.exp);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] op, input logic [31:0] ry,
                      input logic [31:0] rb, input logic brn, input logic inc,
                      input logic [63:0] exp);
    @(negedge clk);
    drive(op, ry, rb, brn, inc);
    push_exp(tag, exp);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    clear = 1'b1;
    drive(OP_ADD, 32'd5, 32'd7, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", RC, 64'h0);

    @(negedge clk);
    clear = 1'b0;
    push_exp("reset_release", 64'h0000_0000_0000_000C);
    @(posedge clk);
    #1;
    pop_check();

    @(negedge clk);
    drive(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    push_exp("add_wrap", 64'h0);
    #1;
    check("hold_between_edges", RC, 64'h0000_0000_0000_000C);
    @(posedge clk);
    #1;
    pop_check();

    step("sub_wrap",  OP_SUB,  32'h0,         32'd1,         1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF);
    step("and",       OP_AND,  32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0, 64'h0000_0000_0F0F_0000);
    step("ori",       OP_ORI,  32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0, 64'h0000_0000_FFFF_0F0F);
    step("shr",       OP_SHR,  32'h8000_0001, 32'd4,         1'b0, 1'b0, 64'h0000_0000_0800_0000);
    step("shra",      OP_SHRA, 32'h8000_0001, 32'd4,         1'b0, 1'b0, 64'h0000_0000_F800_0000);
    step("shl",       OP_SHL,  32'h8000_0001, 32'd4,         1'b0, 1'b0, 64'h0000_0000_0000_0010);
    step("ror",       OP_ROR,  32'h8000_0001, 32'd4,         1'b0, 1'b0, 64'h0000_0000_1800_0000);
    step("rol",       OP_ROL,  32'h8000_0001, 32'd4,         1'b0, 1'b0, 64'h0000_0000_0000_0018);
    step("shr_amt36", OP_SHR,  32'h8000_0001, 32'd36,        1'b0, 1'b0, 64'h0000_0000_0800_0000);
    step("ror_amt0",  OP_ROR,  32'h1234_5678, 32'd32,        1'b0, 1'b0, 64'h0000_0000_1234_5678);
    step("mul_neg",   OP_MUL,  32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
    step("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
    step("div_negb",  OP_DIV,  32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 64'h0000_0001_FFFF_FFFD);
    step("div_zero",  OP_DIV,  32'd9,         32'd0,         1'b0, 1'b0, 64'h0000_0009_FFFF_FFFF);
    step("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'h0000_0000_8000_0000);
    step("neg",       OP_NEG,  32'd0,         32'd5,         1'b0, 1'b0, 64'h0000_0000_FFFF_FFFB);
    step("not",       OP_NOT,  32'd0,         32'h0F0F_0F0F, 1'b0, 1'b0, 64'h0000_0000_F0F0_F0F0);
    step("br_taken",  OP_BR,   32'd100,       32'd20,        1'b1, 1'b0, 64'd120);
    step("br_fall",   OP_BR,   32'd100,       32'd20,        1'b0, 1'b0, 64'd100);
    step("mfhi_pass", OP_MFHI, 32'd3,         32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0000_0000_DEAD_BEEF);
    step("op_zero",   5'b11111, 32'd3,        32'd4,         1'b0, 1'b0, 64'h0);
    step("incpc",     OP_SUB,  32'd1000,      32'd41,        1'b0, 1'b1, 64'd42);

    @(negedge clk);
    drive(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0);
    #2;
    clear = 1'b1;
    #1;
    check("async_clear", RC, 64'h0);
    clear = 1'b0;
    push_exp("after_clear", 64'd2);
    @(posedge clk);
    #1;
    pop_check();

    check("sb_drained", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
